// File: rtl/avalon_bus_arbiter.sv
// Two-master, one-slave Avalon-MM arbiter with round-robin grant, per-transfer
// grant hold, and a watchdog that force-completes transfers the slave never acknowledges.
module avalon_bus_arbiter #(
    parameter int unsigned          ADDR_W   = 32,
    parameter int unsigned          DATA_W   = 32,
    parameter int unsigned          TIMEOUT  = 64,
    parameter logic [DATA_W-1:0]    ERR_DATA = 32'hDEADBEEF
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [ADDR_W-1:0]    m0_address,
    input  logic                 m0_read,
    input  logic                 m0_write,
    input  logic [DATA_W-1:0]    m0_writedata,
    input  logic [DATA_W/8-1:0]  m0_byteenable,
    output logic                 m0_waitrequest,
    output logic [DATA_W-1:0]    m0_readdata,
    input  logic [ADDR_W-1:0]    m1_address,
    input  logic                 m1_read,
    input  logic                 m1_write,
    input  logic [DATA_W-1:0]    m1_writedata,
    input  logic [DATA_W/8-1:0]  m1_byteenable,
    output logic                 m1_waitrequest,
    output logic [DATA_W-1:0]    m1_readdata,
    output logic [ADDR_W-1:0]    s_address,
    output logic                 s_read,
    output logic                 s_write,
    output logic [DATA_W-1:0]    s_writedata,
    output logic [DATA_W/8-1:0]  s_byteenable,
    input  logic                 s_waitrequest,
    input  logic [DATA_W-1:0]    s_readdata,
    output logic [1:0]           grant,
    output logic                 timeout_err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT0 = 2'd1,
        GNT1 = 2'd2
    } state_e;

    localparam logic [7:0] WDOG_LAST = 8'(TIMEOUT - 1);

    state_e              state_q, state_d;
    logic                last_q, last_d;
    logic [7:0]          wdog_q, wdog_d;
    logic                terr_q, terr_d;

    logic                req0_s, req1_s, own1_s, req_own_s, read_own_s;
    logic                wait_own_s;
    logic [DATA_W-1:0]   rdata_own_s;

    assign req0_s     = m0_read | m0_write;
    assign req1_s     = m1_read | m1_write;
    assign own1_s     = (state_q == GNT1);
    assign req_own_s  = own1_s ? req1_s : req0_s;
    assign read_own_s = own1_s ? m1_read : m0_read;
    assign timeout_err = terr_q;

    // State, round-robin history, watchdog and sticky error registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            last_q  <= 1'b1;
            wdog_q  <= 8'd0;
            terr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            wdog_q  <= wdog_d;
            terr_q  <= terr_d;
        end
    end

    // Arbitration, slave mux and completion/watchdog decisions
    always_comb begin
        state_d      = state_q;
        last_d       = last_q;
        wdog_d       = wdog_q;
        terr_d       = terr_q;
        grant        = 2'b00;
        s_address    = '0;
        s_read       = 1'b0;
        s_write      = 1'b0;
        s_writedata  = '0;
        s_byteenable = '0;
        wait_own_s   = 1'b1;
        rdata_own_s  = '0;

        case (state_q)
            IDLE: begin
                wdog_d = 8'd0;
                if (req0_s && req1_s) begin
                    state_d = last_q ? GNT0 : GNT1;
                end else if (req0_s) begin
                    state_d = GNT0;
                end else if (req1_s) begin
                    state_d = GNT1;
                end else begin
                    state_d = IDLE;
                end
            end
            GNT0, GNT1: begin
                grant        = own1_s ? 2'b10 : 2'b01;
                s_address    = own1_s ? m1_address    : m0_address;
                s_read       = own1_s ? m1_read       : m0_read;
                s_write      = own1_s ? m1_write      : m0_write;
                s_writedata  = own1_s ? m1_writedata  : m0_writedata;
                s_byteenable = own1_s ? m1_byteenable : m0_byteenable;
                wait_own_s   = s_waitrequest;
                rdata_own_s  = s_readdata;
                if (!req_own_s) begin
                    // Owner withdrew mid-transfer: drop the grant without crediting it
                    state_d = IDLE;
                    wdog_d  = 8'd0;
                end else if (!s_waitrequest) begin
                    state_d = IDLE;
                    last_d  = own1_s;
                    wdog_d  = 8'd0;
                end else if (wdog_q == WDOG_LAST) begin
                    wait_own_s  = 1'b0;
                    rdata_own_s = read_own_s ? ERR_DATA : s_readdata;
                    terr_d      = 1'b1;
                    state_d     = IDLE;
                    last_d      = own1_s;
                    wdog_d      = 8'd0;
                end else begin
                    wdog_d = wdog_q + 8'd1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        m0_waitrequest = (state_q == GNT0) ? wait_own_s  : 1'b1;
        m0_readdata    = (state_q == GNT0) ? rdata_own_s : '0;
        m1_waitrequest = (state_q == GNT1) ? wait_own_s  : 1'b1;
        m1_readdata    = (state_q == GNT1) ? rdata_own_s : '0;
    end

endmodule

// File: tb/tb_avalon_bus_arbiter.sv
// Directed bench for avalon_bus_arbiter (TIMEOUT = 4) with a small behavioural RAM.
module tb_avalon_bus_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] m0_address, m1_address, s_address;
    logic        m0_read, m0_write, m1_read, m1_write;
    logic [31:0] m0_writedata, m1_writedata, s_writedata;
    logic [3:0]  m0_byteenable, m1_byteenable, s_byteenable;
    logic        m0_waitrequest, m1_waitrequest;
    logic [31:0] m0_readdata, m1_readdata;
    logic        s_read, s_write, s_waitrequest;
    logic [31:0] s_readdata;
    logic [1:0]  grant;
    logic        timeout_err;

    int nvec = 0;
    int nerr = 0;

    logic [31:0] mem [16] = '{1: 32'h24020069, default: 32'h0};

    always #5 clk = ~clk;

    avalon_bus_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(4), .ERR_DATA(32'hDEADBEEF)) dut (
        .clk(clk), .reset(reset),
        .m0_address(m0_address), .m0_read(m0_read), .m0_write(m0_write),
        .m0_writedata(m0_writedata), .m0_byteenable(m0_byteenable),
        .m0_waitrequest(m0_waitrequest), .m0_readdata(m0_readdata),
        .m1_address(m1_address), .m1_read(m1_read), .m1_write(m1_write),
        .m1_writedata(m1_writedata), .m1_byteenable(m1_byteenable),
        .m1_waitrequest(m1_waitrequest), .m1_readdata(m1_readdata),
        .s_address(s_address), .s_read(s_read), .s_write(s_write),
        .s_writedata(s_writedata), .s_byteenable(s_byteenable),
        .s_waitrequest(s_waitrequest), .s_readdata(s_readdata),
        .grant(grant), .timeout_err(timeout_err)
    );

    assign s_readdata = mem[s_address[5:2]];

    // Behavioural RAM: byte-lane write when the slave accepts the command
    always @(posedge clk) begin
        if (s_write && !s_waitrequest) begin
            for (int b = 0; b < 4; b++) begin
                if (s_byteenable[b]) mem[s_address[5:2]][8*b +: 8] <= s_writedata[8*b +: 8];
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    initial begin
        reset = 1'b0;
        m0_address = 32'h0; m0_read = 1'b0; m0_write = 1'b0; m0_writedata = 32'h0; m0_byteenable = 4'h0;
        m1_address = 32'h0; m1_read = 1'b0; m1_write = 1'b0; m1_writedata = 32'h0; m1_byteenable = 4'h0;
        s_waitrequest = 1'b0;

        // Reset state
        sample();
        chk("rst_grant", 32'(grant), 32'h0);
        chk("rst_s_read", 32'(s_read), 32'h0);
        chk("rst_s_write", 32'(s_write), 32'h0);
        chk("rst_m0_wait", 32'(m0_waitrequest), 32'h1);
        chk("rst_m1_wait", 32'(m1_waitrequest), 32'h1);
        chk("rst_terr", 32'(timeout_err), 32'h0);
        reset = 1'b1;

        // m0 write 0x69 to 0x32, byte lane 0
        drive_edge();
        m0_write = 1'b1; m0_address = 32'h32; m0_writedata = 32'h69; m0_byteenable = 4'b0001;
        sample();
        chk("wr_arb_grant", 32'(grant), 32'h0);
        chk("wr_arb_s_write", 32'(s_write), 32'h0);
        sample();
        chk("wr_grant", 32'(grant), 32'h1);
        chk("wr_s_write", 32'(s_write), 32'h1);
        chk("wr_s_addr", s_address, 32'h32);
        chk("wr_s_be", 32'(s_byteenable), 32'h1);
        chk("wr_m0_wait", 32'(m0_waitrequest), 32'h0);
        drive_edge();
        m0_write = 1'b0;
        sample();
        chk("wr_done_grant", 32'(grant), 32'h0);
        chk("wr_done_s_write", 32'(s_write), 32'h0);

        // m0 read back 0x32
        drive_edge();
        m0_read = 1'b1; m0_address = 32'h32;
        sample();
        sample();
        chk("rd_m0_wait", 32'(m0_waitrequest), 32'h0);
        chk("rd_m0_data", m0_readdata, 32'h00000069);
        drive_edge();
        m0_read = 1'b0;

        // Fresh reset, then simultaneous reads from both masters held continuously
        reset = 1'b0;
        #1;
        reset = 1'b1;
        m0_read = 1'b1; m0_address = 32'h32;
        m1_read = 1'b1; m1_address = 32'h04;
        sample();
        chk("rr_g0", 32'(grant), 32'h0);
        sample();
        chk("rr_g1", 32'(grant), 32'h1);
        chk("rr_g1_m1_wait", 32'(m1_waitrequest), 32'h1);
        chk("rr_g1_m1_data", m1_readdata, 32'h0);
        sample();
        chk("rr_g2", 32'(grant), 32'h0);
        sample();
        chk("rr_g3", 32'(grant), 32'h2);
        chk("rr_g3_m1_data", m1_readdata, 32'h24020069);
        sample();
        chk("rr_g4", 32'(grant), 32'h0);
        sample();
        chk("rr_g5", 32'(grant), 32'h1);
        drive_edge();
        m0_read = 1'b0; m1_read = 1'b0;

        // m1 read of 0x04 with three wait cycles
        drive_edge();
        m1_read = 1'b1; m1_address = 32'h04; s_waitrequest = 1'b1;
        sample();
        chk("ws_arb_grant", 32'(grant), 32'h0);
        for (int i = 0; i < 3; i++) begin
            sample();
            chk("ws_grant", 32'(grant), 32'h2);
            chk("ws_m1_wait", 32'(m1_waitrequest), 32'h1);
            chk("ws_m0_wait", 32'(m0_waitrequest), 32'h1);
        end
        drive_edge();
        s_waitrequest = 1'b0;
        sample();
        chk("ws_done_m1_wait", 32'(m1_waitrequest), 32'h0);
        chk("ws_done_m1_data", m1_readdata, 32'h24020069);
        chk("ws_done_m0_wait", 32'(m0_waitrequest), 32'h1);
        chk("ws_done_terr", 32'(timeout_err), 32'h0);
        drive_edge();
        m1_read = 1'b0;

        // m0 read with slave stuck in waitrequest: watchdog fires in 4th GNT0 cycle
        drive_edge();
        m0_read = 1'b1; m0_address = 32'h32; s_waitrequest = 1'b1;
        sample();
        for (int i = 0; i < 3; i++) begin
            sample();
            chk("to_grant", 32'(grant), 32'h1);
            chk("to_m0_wait", 32'(m0_waitrequest), 32'h1);
        end
        sample();
        chk("to_fire_m0_wait", 32'(m0_waitrequest), 32'h0);
        chk("to_fire_m0_data", m0_readdata, 32'hDEADBEEF);
        chk("to_fire_s_read", 32'(s_read), 32'h1);
        chk("to_fire_terr_pre", 32'(timeout_err), 32'h0);
        drive_edge();
        m0_read = 1'b0; s_waitrequest = 1'b0;
        sample();
        chk("to_terr_set", 32'(timeout_err), 32'h1);
        chk("to_idle_grant", 32'(grant), 32'h0);
        drive_edge();
        m1_read = 1'b1; m1_address = 32'h04;
        sample();
        sample();
        chk("to_next_grant", 32'(grant), 32'h2);
        chk("to_next_m1_wait", 32'(m1_waitrequest), 32'h0);
        chk("to_next_m1_data", m1_readdata, 32'h24020069);
        chk("to_terr_sticky", 32'(timeout_err), 32'h1);
        drive_edge();
        m1_read = 1'b0;

        // Asynchronous reset during a stalled GNT1 write
        drive_edge();
        m1_write = 1'b1; m1_address = 32'h08; m1_writedata = 32'h12345678; m1_byteenable = 4'hF;
        s_waitrequest = 1'b1;
        sample();
        sample();
        chk("ar_pre_grant", 32'(grant), 32'h2);
        chk("ar_pre_s_write", 32'(s_write), 32'h1);
        #1;
        reset = 1'b0;
        #1;
        chk("ar_grant", 32'(grant), 32'h0);
        chk("ar_s_write", 32'(s_write), 32'h0);
        chk("ar_m1_wait", 32'(m1_waitrequest), 32'h1);
        chk("ar_terr_clr", 32'(timeout_err), 32'h0);
        drive_edge();
        reset = 1'b1; s_waitrequest = 1'b0;
        m0_read = 1'b1; m0_address = 32'h32;
        sample();
        chk("ar_tie_idle", 32'(grant), 32'h0);
        sample();
        chk("ar_tie_m0", 32'(grant), 32'h1);
        drive_edge();
        m0_read = 1'b0;
        sample();
        chk("ar_gap", 32'(grant), 32'h0);
        sample();
        chk("ar_m1_served", 32'(grant), 32'h2);
        drive_edge();
        m1_write = 1'b0;

        // m0 withdraws in GNT0; pending m1 granted after the return to IDLE
        drive_edge();
        m0_read = 1'b1; m0_address = 32'h32;
        m1_read = 1'b1; m1_address = 32'h04;
        s_waitrequest = 1'b1;
        sample();
        sample();
        chk("wd_grant0", 32'(grant), 32'h1);
        chk("wd_m0_wait", 32'(m0_waitrequest), 32'h1);
        drive_edge();
        m0_read = 1'b0;
        sample();
        chk("wd_s_read", 32'(s_read), 32'h0);
        drive_edge();
        s_waitrequest = 1'b0;
        sample();
        chk("wd_idle", 32'(grant), 32'h0);
        sample();
        chk("wd_m1_grant", 32'(grant), 32'h2);
        chk("wd_m1_data", m1_readdata, 32'h24020069);
        drive_edge();
        m1_read = 1'b0;
        sample();
        chk("wd_end_grant", 32'(grant), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
